// File: rtl/bullet_launcher_pkg.sv
// Shared constants and helpers for the bullet launcher, turret FSM and collision logic.
// Defines FSM state codes, the default fire key, playfield bounds and arithmetic helpers.
package bullet_launcher_pkg;

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StFlight   = 2'd1;
  localparam logic [1:0] StCooldown = 2'd2;

  localparam logic [7:0]  DefFireKey = 8'h2C;
  localparam int unsigned DefXMin    = 0;
  localparam int unsigned DefXMax    = 639;
  localparam int unsigned DefYMin    = 0;
  localparam int unsigned DefYMax    = 479;
  localparam int unsigned DefHitR    = 8;

  // Wide enough that position + 4 * (most negative motion) cannot wrap.
  localparam int unsigned CalcW = 14;

  function automatic logic signed [CalcW-1:0] sext10(input logic [9:0] v);
    return $signed({{(CalcW-10){v[9]}}, v});
  endfunction

  function automatic logic [CalcW-1:0] abs_diff(input logic signed [CalcW-1:0] a,
                                                 input logic signed [CalcW-1:0] b);
    logic signed [CalcW-1:0] d;
    d = a - b;
    return d[CalcW-1] ? CalcW'(-d) : CalcW'(d);
  endfunction

endpackage

// File: rtl/bullet_launcher_if.sv
// Aim, keyboard and frame inputs plus bullet state outputs between the turret FSM,
// the launcher and the sprite mapper.
interface bullet_launcher_if;
  logic       frame_tick;
  logic [7:0] keycode;
  logic [9:0] init_pos_x;
  logic [9:0] init_pos_y;
  logic [9:0] motion_x;
  logic [9:0] motion_y;
  logic [9:0] target_x;
  logic [9:0] target_y;
  logic [9:0] bullet_x;
  logic [9:0] bullet_y;
  logic       bullet_active;
  logic       hit;
  logic       miss;
  logic       ready;
  logic [7:0] shots;

  modport master (
    output frame_tick, keycode, init_pos_x, init_pos_y, motion_x, motion_y, target_x, target_y,
    input  bullet_x, bullet_y, bullet_active, hit, miss, ready, shots
  );

  modport slave (
    input  frame_tick, keycode, init_pos_x, init_pos_y, motion_x, motion_y, target_x, target_y,
    output bullet_x, bullet_y, bullet_active, hit, miss, ready, shots
  );
endinterface

// File: rtl/bullet_step.sv
// Combinational one-frame bullet advance: next position, playfield exit and
// target hit-window test on the advanced position.
module bullet_step
  import bullet_launcher_pkg::*;
#(
  parameter int unsigned SPEED = 1,
  parameter int unsigned X_MIN = DefXMin,
  parameter int unsigned X_MAX = DefXMax,
  parameter int unsigned Y_MIN = DefYMin,
  parameter int unsigned Y_MAX = DefYMax,
  parameter int unsigned HIT_R = DefHitR
) (
  input  logic [9:0] pos_x_i,
  input  logic [9:0] pos_y_i,
  input  logic [9:0] motion_x_i,
  input  logic [9:0] motion_y_i,
  input  logic [9:0] target_x_i,
  input  logic [9:0] target_y_i,
  output logic [9:0] next_x_o,
  output logic [9:0] next_y_o,
  output logic       out_of_bounds_o,
  output logic       in_hit_window_o
);

  localparam logic signed [CalcW-1:0] Speed = CalcW'(SPEED);
  localparam logic signed [CalcW-1:0] XMin  = CalcW'(X_MIN);
  localparam logic signed [CalcW-1:0] XMax  = CalcW'(X_MAX);
  localparam logic signed [CalcW-1:0] YMin  = CalcW'(Y_MIN);
  localparam logic signed [CalcW-1:0] YMax  = CalcW'(Y_MAX);
  localparam logic [CalcW-1:0]        HitR  = CalcW'(HIT_R);

  logic signed [CalcW-1:0] nx, ny;

  always_comb begin
    nx = $signed({{(CalcW-10){1'b0}}, pos_x_i}) + sext10(motion_x_i) * Speed;
    ny = $signed({{(CalcW-10){1'b0}}, pos_y_i}) + sext10(motion_y_i) * Speed;
    out_of_bounds_o = (nx < XMin) || (nx > XMax) || (ny < YMin) || (ny > YMax);
    in_hit_window_o = (abs_diff(nx, $signed({{(CalcW-10){1'b0}}, target_x_i})) <= HitR) &&
                      (abs_diff(ny, $signed({{(CalcW-10){1'b0}}, target_y_i})) <= HitR);
    next_x_o = nx[9:0];
    next_y_o = ny[9:0];
  end

endmodule

// File: rtl/bullet_launcher.sv
// Fire-key edge detect, single-bullet flight FSM, cooldown timer and saturating shot count.
// Position advances one step per frame_tick using the motion latched at launch.
module bullet_launcher
  import bullet_launcher_pkg::*;
#(
  parameter logic [7:0]  FIRE_KEY        = DefFireKey,
  parameter int unsigned SPEED           = 1,
  parameter int unsigned X_MIN           = DefXMin,
  parameter int unsigned X_MAX           = DefXMax,
  parameter int unsigned Y_MIN           = DefYMin,
  parameter int unsigned Y_MAX           = DefYMax,
  parameter int unsigned HIT_R           = DefHitR,
  parameter int unsigned COOLDOWN_FRAMES = 30
) (
  input logic              Clk,
  input logic              Reset,
  bullet_launcher_if.slave bus
);

  localparam int unsigned CntW = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
  localparam logic [CntW-1:0] CntLast =
      CntW'((COOLDOWN_FRAMES == 0) ? 0 : COOLDOWN_FRAMES - 1);

  logic [1:0]      state_q, state_d;
  logic            fire_prev_q;
  logic [9:0]      bx_q, bx_d, by_q, by_d;
  logic [9:0]      mx_q, mx_d, my_q, my_d;
  logic            active_q, active_d;
  logic            hit_q, hit_d, miss_q, miss_d;
  logic [7:0]      shots_q, shots_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic       fire_now, fire_edge;
  logic [9:0] step_nx, step_ny;
  logic       step_oob, step_hit;

  assign fire_now  = (bus.keycode == FIRE_KEY);
  assign fire_edge = fire_now & ~fire_prev_q;

  bullet_step #(
    .SPEED(SPEED),
    .X_MIN(X_MIN),
    .X_MAX(X_MAX),
    .Y_MIN(Y_MIN),
    .Y_MAX(Y_MAX),
    .HIT_R(HIT_R)
  ) u_step (
    .pos_x_i        (bx_q),
    .pos_y_i        (by_q),
    .motion_x_i     (mx_q),
    .motion_y_i     (my_q),
    .target_x_i     (bus.target_x),
    .target_y_i     (bus.target_y),
    .next_x_o       (step_nx),
    .next_y_o       (step_ny),
    .out_of_bounds_o(step_oob),
    .in_hit_window_o(step_hit)
  );

  always_comb begin
    state_d  = state_q;
    bx_d     = bx_q;
    by_d     = by_q;
    mx_d     = mx_q;
    my_d     = my_q;
    active_d = active_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    shots_d  = shots_q;
    cnt_d    = cnt_q;
    case (state_q)
      StIdle: begin
        if (fire_edge) begin
          bx_d     = bus.init_pos_x;
          by_d     = bus.init_pos_y;
          mx_d     = bus.motion_x;
          my_d     = bus.motion_y;
          active_d = 1'b1;
          if (shots_q != 8'hFF) shots_d = shots_q + 8'd1;
          state_d  = StFlight;
        end
      end
      StFlight: begin
        // Bounds win over the hit window: an exiting step never scores.
        if (bus.frame_tick) begin
          if (step_oob) begin
            miss_d   = 1'b1;
            active_d = 1'b0;
            cnt_d    = '0;
            state_d  = StCooldown;
          end else begin
            bx_d = step_nx;
            by_d = step_ny;
            if (step_hit) begin
              hit_d    = 1'b1;
              active_d = 1'b0;
              cnt_d    = '0;
              state_d  = StCooldown;
            end
          end
        end
      end
      StCooldown: begin
        if (COOLDOWN_FRAMES == 0) begin
          state_d = StIdle;
        end else if (bus.frame_tick) begin
          if (cnt_q == CntLast) begin
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      fire_prev_q <= 1'b0;
      bx_q        <= '0;
      by_q        <= '0;
      mx_q        <= '0;
      my_q        <= '0;
      active_q    <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      shots_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      fire_prev_q <= fire_now;
      bx_q        <= bx_d;
      by_q        <= by_d;
      mx_q        <= mx_d;
      my_q        <= my_d;
      active_q    <= active_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      shots_q     <= shots_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.bullet_x      = bx_q;
  assign bus.bullet_y      = by_q;
  assign bus.bullet_active = active_q;
  assign bus.hit           = hit_q;
  assign bus.miss          = miss_q;
  assign bus.ready         = (state_q == StIdle);
  assign bus.shots         = shots_q;

endmodule

// File: tb/tb_bullet_launcher.sv
// Randomized scoreboard bench for bullet_launcher: a frame-by-frame integer model predicts
// each shot's trajectory and outcome; a monitor checks every hit/miss pulse against it.
module tb_bullet_launcher;

  localparam int Speed   = 1;
  localparam int HitR    = 8;
  localparam int Cool    = 30;
  localparam int XMaxPf  = 639;
  localparam int YMaxPf  = 479;
  localparam logic [7:0] FireKey = 8'h2C;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  bullet_launcher_if bus ();

  bullet_launcher #(
    .SPEED          (Speed),
    .HIT_R          (HitR),
    .COOLDOWN_FRAMES(Cool)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  typedef struct {
    int kind;  // 1 = hit, 2 = miss
    int x;
    int y;
    int shots;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   launches = 0;
  int   traj_x[$];
  int   traj_y[$];
  int   mdl_kind;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Walk the bullet one frame at a time; record the position seen after each frame.
  task automatic model_shot(input int ix, input int iy, input int mx, input int my,
                            input int tx, input int ty);
    int x, y, nx, ny;
    x = ix;
    y = iy;
    mdl_kind = 0;
    traj_x.delete();
    traj_y.delete();
    for (int k = 0; k < 4000; k++) begin
      nx = x + mx * Speed;
      ny = y + my * Speed;
      if (nx < 0 || nx > XMaxPf || ny < 0 || ny > YMaxPf) begin
        traj_x.push_back(x);
        traj_y.push_back(y);
        mdl_kind = 2;
        break;
      end
      x = nx;
      y = ny;
      traj_x.push_back(x);
      traj_y.push_back(y);
      if (iabs(x - tx) <= HitR && iabs(y - ty) <= HitR) begin
        mdl_kind = 1;
        break;
      end
    end
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (Reset === 1'b0 && (bus.hit === 1'b1 || bus.miss === 1'b1)) begin
      check("hit_miss_exclusive", int'(bus.hit & bus.miss), 0);
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("end_kind", bus.hit ? 1 : 2, e.kind);
        check("end_x", int'(bus.bullet_x), e.x);
        check("end_y", int'(bus.bullet_y), e.y);
        check("end_shots", int'(bus.shots), e.shots);
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_x"}, int'(bus.bullet_x), 0);
    check({tag, "_y"}, int'(bus.bullet_y), 0);
    check({tag, "_active"}, int'(bus.bullet_active), 0);
    check({tag, "_hit"}, int'(bus.hit), 0);
    check({tag, "_miss"}, int'(bus.miss), 0);
    check({tag, "_ready"}, int'(bus.ready), 1);
    check({tag, "_shots"}, int'(bus.shots), 0);
  endtask

  // abort >= 0: assert Reset after that many flight frames instead of finishing the shot.
  task automatic fire_shot(input int ix, input int iy, input int mx, input int my,
                           input int tx, input int ty, input int abort, input int hold);
    int   n, exp_shots;
    exp_t e;
    model_shot(ix, iy, mx, my, tx, ty);
    n = traj_x.size();
    if (mdl_kind == 0) begin
      check("model_terminates", 0, 1);
      return;
    end
    bus.init_pos_x = 10'(ix);
    bus.init_pos_y = 10'(iy);
    bus.motion_x   = 10'(mx);
    bus.motion_y   = 10'(my);
    bus.target_x   = 10'(tx);
    bus.target_y   = 10'(ty);
    bus.keycode    = FireKey;
    launches++;
    exp_shots = (launches > 255) ? 255 : launches;
    if (abort < 0) begin
      e.kind  = mdl_kind;
      e.x     = traj_x[n-1];
      e.y     = traj_y[n-1];
      e.shots = exp_shots;
      sb_q.push_back(e);
    end
    step();
    check("launch_active", int'(bus.bullet_active), 1);
    check("launch_x", int'(bus.bullet_x), ix);
    check("launch_y", int'(bus.bullet_y), iy);
    check("launch_ready", int'(bus.ready), 0);
    check("launch_shots", int'(bus.shots), exp_shots);
    for (int h = 1; h < hold; h++) step();
    bus.keycode = 8'h00;
    step();
    bus.keycode = FireKey;
    step();
    bus.keycode = 8'h00;
    check("flight_edge_shots", int'(bus.shots), exp_shots);
    check("flight_edge_active", int'(bus.bullet_active), 1);
    check("flight_edge_x", int'(bus.bullet_x), ix);
    for (int k = 0; k < n; k++) begin
      if (k == abort) begin
        #2;
        Reset = 1'b1;
        #1;
        check_reset_values("midflight_reset");
        step();
        check_reset_values("midflight_reset_held");
        Reset = 1'b0;
        launches = 0;
        step();
        check_reset_values("after_reset");
        return;
      end
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      // Aim inputs wander during flight; the latched motion must be unaffected.
      bus.init_pos_x = 10'($urandom);
      bus.init_pos_y = 10'($urandom);
      bus.motion_x   = 10'($urandom);
      bus.motion_y   = 10'($urandom);
      check("flight_x", int'(bus.bullet_x), traj_x[k]);
      check("flight_y", int'(bus.bullet_y), traj_y[k]);
      check("flight_active", int'(bus.bullet_active), (k == n - 1) ? 0 : 1);
    end
    for (int c = 0; c < Cool; c++) begin
      if (c == 10) bus.keycode = FireKey;
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      if (c == Cool - 2) check("cooldown_not_ready", int'(bus.ready), 0);
    end
    check("cooldown_ready", int'(bus.ready), 1);
    check("cooldown_shots", int'(bus.shots), exp_shots);
    check("cooldown_inactive", int'(bus.bullet_active), 0);
    bus.keycode = 8'h00;
    step();
  endtask

  initial begin
    int ix, iy, mx, my, tx, ty, k;
    Reset          = 1'b1;
    bus.frame_tick = 1'b0;
    bus.keycode    = 8'h00;
    bus.init_pos_x = '0;
    bus.init_pos_y = '0;
    bus.motion_x   = '0;
    bus.motion_y   = '0;
    bus.target_x   = '0;
    bus.target_y   = '0;
    step();
    check_reset_values("reset");
    step();
    Reset = 1'b0;
    step();
    check_reset_values("post_reset");

    fire_shot(85, 40, 1, 0, 600, 400, -1, 10);    // held key launches once
    fire_shot(300, 200, 3, -2, 900, 900, 4, 1);   // reset mid-flight
    fire_shot(40, 43, -1, -2, 600, 400, -1, 1);   // (37,37) after three frames
    fire_shot(85, 40, 1, 0, 95, 40, -1, 1);       // hit on frame 2 at x=87
    fire_shot(5, 40, -4, 0, 600, 400, -1, 1);     // x=1, then -3 is a miss
    fire_shot(2, 40, -4, 0, 0, 40, -1, 1);        // exit beats nearby target
    fire_shot(635, 470, 4, 3, 900, 10, -1, 1);    // right/bottom edges inclusive

    for (int s = 0; s < 30; s++) begin
      ix = $urandom_range(0, XMaxPf);
      iy = $urandom_range(0, YMaxPf);
      mx = $urandom_range(1, 9);
      if ($urandom_range(0, 1) == 1) mx = -mx;
      my = $urandom_range(0, 18) - 9;
      if ($urandom_range(0, 1) == 1) begin
        k  = $urandom_range(1, 20);
        tx = ix + mx * Speed * k + $urandom_range(0, 12) - 6;
        ty = iy + my * Speed * k + $urandom_range(0, 12) - 6;
      end else begin
        tx = $urandom_range(0, 1023);
        ty = $urandom_range(0, 1023);
      end
      tx = (tx < 0) ? 0 : (tx > 1023) ? 1023 : tx;
      ty = (ty < 0) ? 0 : (ty > 1023) ? 1023 : ty;
      fire_shot(ix, iy, mx, my, tx, ty, -1, 1);
    end

    while (launches < 257) fire_shot(0, 100, -1, 0, 600, 400, -1, 1);
    check("shots_saturated", int'(bus.shots), 255);

    repeat (3) step();
    check("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
